// File: rtl/mips_pkg.sv
// Shared constants and helpers for the MIPS pipeline front end.
package mips_pkg;

   localparam logic [31:0] PC_INCREMENT = 32'd4;
   localparam logic [31:0] RESET_PC     = 32'h0040_0000;
   localparam int unsigned MEMORY_DEPTH = 256;
   localparam logic [31:0] NOP_WORD     = 32'h0000_0000;
   localparam logic [5:0]  OPCODE_J     = 6'h02;
   localparam logic [5:0]  OPCODE_JAL   = 6'h03;

   // Pseudo-direct j/jal target: PC region bits above a word-aligned 26-bit index.
   function automatic logic [31:0] jump_target(input logic [3:0]  pc_hi,
                                               input logic [25:0] index);
      return {pc_hi, index, 2'b00};
   endfunction

endpackage

// File: rtl/if_id_stage_register.sv
// Generic pipeline stage register: instruction, pc+4 and valid, with hold and bubble insertion.
module if_id_stage_register
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC_VALUE = mips_pkg::RESET_PC,
   parameter logic [31:0] BUBBLE_WORD    = mips_pkg::NOP_WORD
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        enable_i,
   input  logic        flush_i,
   input  logic [31:0] instruction_i,
   input  logic [31:0] pc_plus_4_i,
   input  logic        valid_i,
   output logic [31:0] instruction_o,
   output logic [31:0] pc_plus_4_o,
   output logic        valid_o
);

   logic [31:0] instruction_q;
   logic [31:0] pc_plus_4_q;
   logic        valid_q;

   // Flush wins over hold; a bubble leaves pc_plus_4 untouched.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         instruction_q <= BUBBLE_WORD;
         pc_plus_4_q   <= RESET_PC_VALUE;
         valid_q       <= 1'b0;
      end else if (flush_i) begin
         instruction_q <= BUBBLE_WORD;
         valid_q       <= 1'b0;
      end else if (enable_i) begin
         instruction_q <= instruction_i;
         pc_plus_4_q   <= pc_plus_4_i;
         valid_q       <= valid_i;
      end
   end

   assign instruction_o = instruction_q;
   assign pc_plus_4_o   = pc_plus_4_q;
   assign valid_o       = valid_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch front end: PC register, next-PC arbitration, squash generation and IF/ID register.
module fetch_sequencer
   import mips_pkg::*;
#(
   parameter logic [31:0] PC_INCREMENT = mips_pkg::PC_INCREMENT,
   parameter logic [31:0] RESET_PC     = mips_pkg::RESET_PC,
   parameter int unsigned MEMORY_DEPTH = mips_pkg::MEMORY_DEPTH,
   parameter logic [31:0] NOP_WORD     = mips_pkg::NOP_WORD
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        branch_taken_me,
   input  logic [31:0] branch_target_me,
   input  logic        jr_ex,
   input  logic [31:0] jr_target_ex,
   input  logic        jump_id,
   input  logic [31:0] instruction_if,
   output logic [31:0] pc_if,
   output logic [31:0] instruction_id,
   output logic [31:0] pc_plus_4_id,
   output logic        valid_id,
   output logic        flush_id_ex,
   output logic        flush_ex_me,
   output logic        fetch_fault,
   output logic [15:0] stall_count
);

   logic [31:0] pc_q, pc_d;
   logic        fault_q, fault_d;
   logic [15:0] stall_cnt_q, stall_cnt_d;

   logic [31:0] pc_seq_s;
   logic [31:0] jump_target_s;
   logic        jump_take_s;
   logic        redirect_s;
   logic [31:0] offset_s;
   logic [31:0] word_idx_s;
   logic        fault_hit_s;

   assign pc_seq_s      = pc_q + PC_INCREMENT;
   assign jump_target_s = jump_target(pc_plus_4_id[31:28], instruction_id[25:0]);
   assign jump_take_s   = jump_id & valid_id;
   assign redirect_s    = branch_taken_me | jr_ex | jump_take_s;

   // Next-PC arbitration, oldest redirect first; the j/jal itself is never flushed downstream.
   always_comb begin
      pc_d        = pc_q;
      flush_id_ex = 1'b0;
      flush_ex_me = 1'b0;
      if (branch_taken_me) begin
         pc_d        = branch_target_me;
         flush_id_ex = 1'b1;
         flush_ex_me = 1'b1;
      end else if (jr_ex) begin
         pc_d        = jr_target_ex;
         flush_id_ex = 1'b1;
      end else if (jump_take_s) begin
         pc_d = jump_target_s;
      end else if (stall) begin
         pc_d = pc_q;
      end else begin
         pc_d = pc_seq_s;
      end
   end

   assign offset_s    = pc_d - RESET_PC;
   assign word_idx_s  = offset_s >> 5'd2;
   assign fault_hit_s = (word_idx_s >= 32'(MEMORY_DEPTH)) || (pc_d[1:0] != 2'b00);

   // Sticky fault flag and saturating stall counter.
   always_comb begin
      fault_d     = fault_q | fault_hit_s;
      stall_cnt_d = stall_cnt_q;
      if (stall && !redirect_s && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end else begin
         stall_cnt_d = stall_cnt_q;
      end
   end

   // Front-end state registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q        <= RESET_PC;
         fault_q     <= 1'b0;
         stall_cnt_q <= 16'd0;
      end else begin
         pc_q        <= pc_d;
         fault_q     <= fault_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   if_id_stage_register #(
      .RESET_PC_VALUE (RESET_PC),
      .BUBBLE_WORD    (NOP_WORD)
   ) u_if_id (
      .clk_i         (clk),
      .reset_i       (reset),
      .enable_i      (~stall),
      .flush_i       (redirect_s),
      .instruction_i (instruction_if),
      .pc_plus_4_i   (pc_seq_s),
      .valid_i       (1'b1),
      .instruction_o (instruction_id),
      .pc_plus_4_o   (pc_plus_4_id),
      .valid_o       (valid_id)
   );

   assign pc_if       = pc_q;
   assign fetch_fault = fault_q;
   assign stall_count = stall_cnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed test-plan scenarios plus randomized traffic vs. a reference model.
module tb_fetch_sequencer;
   import mips_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        stall = 1'b0;
   logic        branch_taken_me = 1'b0;
   logic [31:0] branch_target_me = 32'd0;
   logic        jr_ex = 1'b0;
   logic [31:0] jr_target_ex = 32'd0;
   logic        jump_id = 1'b0;
   logic [31:0] instruction_if = 32'd0;
   logic [31:0] pc_if, instruction_id, pc_plus_4_id;
   logic        valid_id, flush_id_ex, flush_ex_me, fetch_fault;
   logic [15:0] stall_count;

   fetch_sequencer dut (
      .clk(clk), .reset(reset), .stall(stall),
      .branch_taken_me(branch_taken_me), .branch_target_me(branch_target_me),
      .jr_ex(jr_ex), .jr_target_ex(jr_target_ex), .jump_id(jump_id),
      .instruction_if(instruction_if), .pc_if(pc_if),
      .instruction_id(instruction_id), .pc_plus_4_id(pc_plus_4_id),
      .valid_id(valid_id), .flush_id_ex(flush_id_ex), .flush_ex_me(flush_ex_me),
      .fetch_fault(fetch_fault), .stall_count(stall_count)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state: what the fetch stage should hold at any point.
   logic [31:0] m_pc, m_instr, m_pc4;
   logic        m_valid, m_fault;
   int          m_stalls;
   logic [31:0] rom [256];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] rom_word(input logic [31:0] pc);
      logic [31:0] idx;
      idx = (pc - RESET_PC) >> 2;
      if (idx < 32'd256) return rom[idx[7:0]];
      return 32'h2008_0005;
   endfunction

   task automatic model_reset();
      m_pc = RESET_PC; m_instr = NOP_WORD; m_pc4 = RESET_PC;
      m_valid = 1'b0; m_fault = 1'b0; m_stalls = 0;
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      stall = 1'b0; branch_taken_me = 1'b0; jr_ex = 1'b0; jump_id = 1'b0;
      repeat (2) @(posedge clk);
      model_reset();
      #2 reset = 1'b0;
   endtask

   // One clock of stimulus: drive at negedge, check, then advance the model over the posedge.
   task automatic step(input bit st, input bit br, input logic [31:0] bt,
                       input bit jr, input logic [31:0] jt, input bit glitch, input bit do_chk);
      logic        jid;
      logic [31:0] ins, nxt;
      @(negedge clk);
      jid = (m_valid && (m_instr[31:26] == OPCODE_J || m_instr[31:26] == OPCODE_JAL))
            || (glitch && !m_valid);
      ins = rom_word(m_pc);
      stall = st; branch_taken_me = br; branch_target_me = bt;
      jr_ex = jr; jr_target_ex = jt; jump_id = jid; instruction_if = ins;
      #1;
      if (do_chk) begin
         check_eq("pc_if", pc_if, m_pc);
         check_eq("instruction_id", instruction_id, m_instr);
         check_eq("pc_plus_4_id", pc_plus_4_id, m_pc4);
         check_eq("valid_id", {31'd0, valid_id}, {31'd0, m_valid});
         check_eq("fetch_fault", {31'd0, fetch_fault}, {31'd0, m_fault});
         check_eq("stall_count", {16'd0, stall_count}, 32'(m_stalls));
         check_eq("flush_id_ex", {31'd0, flush_id_ex}, {31'd0, br | jr});
         check_eq("flush_ex_me", {31'd0, flush_ex_me}, {31'd0, br});
      end
      @(posedge clk);
      if (br) nxt = bt;
      else if (jr) nxt = jt;
      else if (jid && m_valid) nxt = {m_pc4[31:28], m_instr[25:0], 2'b00};
      else if (st) nxt = m_pc;
      else nxt = m_pc + 32'd4;
      if (br || jr || (jid && m_valid)) begin
         m_instr = NOP_WORD; m_valid = 1'b0;
      end else if (st) begin
         if (m_stalls < 65535) m_stalls++;
      end else begin
         m_instr = ins; m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
      end
      if ((((nxt - RESET_PC) >> 2) >= 32'd256) || (nxt[1:0] != 2'b00)) m_fault = 1'b1;
      m_pc = nxt;
   endtask

   task automatic random_run(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         bit st, br, jr, gl;
         logic [31:0] bt, jt;
         st = ($urandom_range(0, 99) < 20);
         br = ($urandom_range(0, 99) < 8);
         jr = ($urandom_range(0, 99) < 6);
         gl = ($urandom_range(0, 99) < 10);
         bt = RESET_PC + ($urandom_range(0, 255) << 2);
         jt = ($urandom_range(0, 99) < 5) ? $urandom : RESET_PC + ($urandom_range(0, 255) << 2);
         step(st, br, bt, jr, jt, gl, 1'b1);
      end
   endtask

   initial begin
      logic [31:0] jword;
      model_reset();
      for (int i = 0; i < 256; i++) rom[i] = 32'h2008_0005;
      jword = {OPCODE_J, 26'h010_0004};
      rom[3] = jword;

      apply_reset();
      check_eq("rst_pc", pc_if, 32'h0040_0000);
      check_eq("rst_valid", {31'd0, valid_id}, 32'd0);
      check_eq("rst_instr", instruction_id, 32'h0000_0000);

      step(0, 0, 0, 0, 0, 0, 1); #1;
      check_eq("walk_pc1", pc_if, 32'h0040_0004);
      check_eq("walk_valid", {31'd0, valid_id}, 32'd1);
      check_eq("walk_instr", instruction_id, 32'h2008_0005);
      step(0, 0, 0, 0, 0, 0, 1); #1;
      check_eq("walk_pc2", pc_if, 32'h0040_0008);
      repeat (3) step(1, 0, 0, 0, 0, 0, 1);
      #1;
      check_eq("stall_hold_pc", pc_if, 32'h0040_0008);
      check_eq("stall_cnt3", {16'd0, stall_count}, 32'd3);
      step(0, 0, 0, 0, 0, 0, 1); #1;
      check_eq("resume_pc", pc_if, 32'h0040_000C);
      step(0, 0, 0, 0, 0, 0, 1); #1;
      check_eq("j_in_id", instruction_id, jword);
      step(0, 0, 0, 0, 0, 0, 1); #1;
      check_eq("j_target", pc_if, 32'h0040_0010);
      check_eq("j_bubble", {31'd0, valid_id}, 32'd0);

      step(1, 1, 32'h0040_0040, 1, 32'h0040_0100, 0, 1); #1;
      check_eq("br_pc", pc_if, 32'h0040_0040);
      check_eq("br_bubble", {31'd0, valid_id}, 32'd0);
      check_eq("br_no_stall_cnt", {16'd0, stall_count}, 32'd3);

      step(0, 0, 0, 1, 32'h0040_0800, 0, 1); #1;
      check_eq("jr_pc", pc_if, 32'h0040_0800);
      check_eq("fault_set", {31'd0, fetch_fault}, 32'd1);
      repeat (3) step(0, 0, 0, 0, 0, 0, 1);
      #1;
      check_eq("fault_sticky", {31'd0, fetch_fault}, 32'd1);

      step(0, 0, 0, 1, 32'hFFFF_FFFC, 0, 1);
      step(0, 0, 0, 0, 0, 0, 1); #1;
      check_eq("pc_wrap", pc_if, 32'h0000_0000);

      apply_reset();
      repeat (5) step(1, 0, 0, 0, 0, 0, 1);
      #1;
      check_eq("stall_cnt5", {16'd0, stall_count}, 32'd5);
      #2 reset = 1'b1;
      #1;
      check_eq("async_pc", pc_if, 32'h0040_0000);
      check_eq("async_cnt", {16'd0, stall_count}, 32'd0);
      check_eq("async_valid", {31'd0, valid_id}, 32'd0);
      check_eq("async_fault", {31'd0, fetch_fault}, 32'd0);
      check_eq("async_pc4", pc_plus_4_id, 32'h0040_0000);
      apply_reset();

      for (int i = 0; i < 256; i++) begin
         if ($urandom_range(0, 99) < 15)
            rom[i] = {(($urandom_range(0, 1) == 0) ? OPCODE_J : OPCODE_JAL),
                      26'((RESET_PC >> 2) + $urandom_range(0, 255))};
         else
            rom[i] = $urandom;
      end
      random_run(400);
      apply_reset();
      random_run(400);

      apply_reset();
      for (int i = 0; i < 65540; i++) step(1, 0, 0, 0, 0, 0, 1'b0);
      step(1, 0, 0, 0, 0, 0, 1'b1); #1;
      check_eq("stall_sat", {16'd0, stall_count}, 32'h0000_FFFF);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
